// File: rtl/serial_adder_nbit.sv
// Bit-serial adder: one result bit per clock, LSB first, behind valid/ready ports.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module serial_adder_nbit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             c_q;
    logic [WIDTH-1:0] psum_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q;
`endif

    logic             bit_s_d;
    logic             bit_c_d;
    logic [WIDTH-1:0] psum_d;

    // Full-adder slice on the current operand LSBs and the carry flop.
    always_comb begin
        bit_s_d = a_q[0] ^ b_q[0] ^ c_q;
        bit_c_d = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));
        psum_d  = {bit_s_d, psum_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= 1'b0;
            psum_q      <= '0;
            cnt_q       <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= a;
                        b_q        <= b;
                        c_q        <= cin;
                        psum_q     <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    a_q    <= a_q >> 1;
                    b_q    <= b_q >> 1;
                    c_q    <= bit_c_d;
                    psum_q <= psum_d;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    // Results are published only here, so sum/cout never show partial values.
                    if (cnt_q == CNT_LAST) begin
                        sum_q       <= psum_d;
                        cout_q      <= bit_c_d;
`ifdef SERIAL_ADDER_OVF_EN
                        ovf_q       <= c_q ^ bit_c_d;
`endif
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule
